// File: rtl/fpu_norm_stage.sv
// rtl/fpu_norm_stage.sv - FPU adder normalise/round/pack stage with valid/ready handshake
module fpu_norm_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [24:0] mant_i,
  input  logic [7:0]  exp_i,
  input  logic        sign_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [24:0] mant_q, mant_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;

  logic        rnd_up;
  logic [24:0] rnd_sum;
  logic [23:0] rnd_m;
  logic [8:0]  rnd_exp;

  // Carry-out path: drop the guard bit, round to nearest even, renormalise a round carry
  always_comb begin
    rnd_up  = mant_q[0] & mant_q[1];
    rnd_sum = {1'b0, mant_q[24:1]} + {24'h0, rnd_up};
    if (rnd_sum[24]) begin
      rnd_m   = 24'h800000;
      rnd_exp = {1'b0, exp_q} + 9'd2;
    end else begin
      rnd_m   = rnd_sum[23:0];
      rnd_exp = {1'b0, exp_q} + 9'd1;
    end
  end

  // Next-state logic: accept in IDLE, one normalisation rule per cycle in NORM, hold in DONE
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          mant_d  = mant_i;
          exp_d   = exp_i;
          sign_d  = sign_i;
          state_d = NORM;
        end
      end
      NORM: begin
        state_d = DONE;
        if (exp_q == 8'hFF) begin
          result_d = {sign_q, 8'hFF, 23'h0};
        end else if (mant_q == 25'h0) begin
          result_d = {sign_q, 31'h0};
        end else if (exp_q == 8'h00) begin
          result_d = {sign_q, 31'h0};
        end else if (mant_q[24]) begin
          if (rnd_exp >= 9'd255) begin
            result_d = {sign_q, 8'hFF, 23'h0};
          end else begin
            result_d = {sign_q, rnd_exp[7:0], rnd_m[22:0]};
          end
        end else if (mant_q[23]) begin
          result_d = {sign_q, exp_q, mant_q[22:0]};
        end else if (exp_q == 8'h01) begin
          // Another shift would need a denormal exponent; flush instead
          result_d = {sign_q, 31'h0};
        end else begin
          mant_d  = {mant_q[23:0], 1'b0};
          exp_d   = exp_q - 8'd1;
          state_d = NORM;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mant_q   <= 25'h0;
      exp_q    <= 8'h0;
      sign_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_fpu_norm_stage.sv
// tb/tb_fpu_norm_stage.sv - self-checking bench for fpu_norm_stage
module tb_fpu_norm_stage;

  logic        clk;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [24:0] mant_i;
  logic [7:0]  exp_i;
  logic        sign_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q[$];

  fpu_norm_stage dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .mant_i   (mant_i),
    .exp_i    (exp_i),
    .sign_i   (sign_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand for one accept edge and record its expected result
  task automatic send(input logic [24:0] m, input logic [7:0] e, input logic s, input logic [31:0] res);
    @(negedge clk);
    valid_i = 1'b1;
    mant_i  = m;
    exp_i   = e;
    sign_i  = s;
    sb_q.push_back(res);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    mant_i  = 25'($urandom);
    exp_i   = 8'($urandom);
    sign_i  = 1'($urandom);
  endtask

  // Wait (bounded) for valid_o; edges counts the accept edge as 1
  task automatic collect(output int edges, output bit ok, output bit rdy_hi, output logic [31:0] expv);
    edges  = 1;
    ok     = 1'b0;
    rdy_hi = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (ready_o !== 1'b0) rdy_hi = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    if (sb_q.size() > 0) expv = sb_q.pop_front();
    else expv = 32'hxxxxxxxx;
  endtask

  task automatic retire();
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    int n; bit ok; bit rh; logic [31:0] ev;
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_i = 1'($urandom); ready_i = 1'($urandom);
      mant_i = 25'($urandom); exp_i = 8'($urandom); sign_i = 1'($urandom);
    end
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result_o); end
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0; rst_ni = 1'b1;
    send(25'h0800000, 8'h7F, 1'b0, 32'h3F800000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL one_result: got %h valid=%b want %h", result_o, ok, ev); end
    checks++; if (n !== 2) begin errors++; $display("FAIL one_latency: got %0d edges want 2", n); end
    retire();
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL one_retire: got ready=%b valid=%b want 1/0", ready_o, valid_o); end
  endtask

  task automatic test_carry();
    int n; bit ok; bit rh; logic [31:0] ev;
    send(25'h1000001, 8'h7F, 1'b0, 32'h40000000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL carry_tie_even: got %h want %h", result_o, ev); end
    checks++; if (n !== 2) begin errors++; $display("FAIL carry_latency: got %0d edges want 2", n); end
    retire();
    send(25'h1FFFFFF, 8'h7F, 1'b0, 32'h40800000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL carry_round_carry: got %h want %h", result_o, ev); end
    retire();
    send(25'h1000003, 8'h80, 1'b1, 32'hC0800002);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL carry_round_up: got %h want %h", result_o, ev); end
    retire();
  endtask

  task automatic test_shift();
    int n; bit ok; bit rh; logic [31:0] ev;
    send(25'h0000001, 8'h7F, 1'b1, 32'hB4000000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL shift23_result: got %h want %h", result_o, ev); end
    checks++; if (n !== 25) begin errors++; $display("FAIL shift23_latency: got %0d edges want 25", n); end
    checks++; if (rh !== 1'b0) begin errors++; $display("FAIL shift23_ready_low: got ready high=%b want 0", rh); end
    retire();
  endtask

  task automatic test_underflow();
    int n; bit ok; bit rh; logic [31:0] ev;
    send(25'h0000000, 8'h55, 1'b0, 32'h00000000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL cancel_result: got %h want %h", result_o, ev); end
    checks++; if (n !== 2) begin errors++; $display("FAIL cancel_latency: got %0d edges want 2", n); end
    retire();
    send(25'h0000100, 8'h03, 1'b1, 32'h80000000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL flush_result: got %h want %h", result_o, ev); end
    checks++; if (n !== 4) begin errors++; $display("FAIL flush_latency: got %0d edges want 4", n); end
    retire();
    send(25'h0800000, 8'h00, 1'b1, 32'h80000000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL zero_exp_flush: got %h want %h", result_o, ev); end
    retire();
  endtask

  task automatic test_overflow();
    int n; bit ok; bit rh; logic [31:0] ev;
    send(25'h1000000, 8'hFE, 1'b0, 32'h7F800000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL ovf_result: got %h want %h", result_o, ev); end
    retire();
    send(25'h0812345, 8'hFF, 1'b1, 32'hFF800000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL inf_pass: got %h want %h", result_o, ev); end
    checks++; if (n !== 2) begin errors++; $display("FAIL inf_latency: got %0d edges want 2", n); end
    retire();
  endtask

  task automatic test_backpressure();
    int n; bit ok; bit rh; logic [31:0] ev; int bad;
    send(25'h0C00000, 8'h80, 1'b0, 32'h40400000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL bp_result: got %h want %h", result_o, ev); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_i = 1'b1; mant_i = 25'($urandom); exp_i = 8'($urandom); sign_i = 1'($urandom);
      @(posedge clk);
      #1;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== ev) bad++;
    end
    valid_i = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    retire();
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL bp_retire: got ready=%b valid=%b want 1/0", ready_o, valid_o); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL bp_no_ghost: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
  endtask

  task automatic test_abort();
    int n; bit ok; bit rh; logic [31:0] ev;
    send(25'h0000008, 8'h80, 1'b1, 32'hB6000000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    sb_q.delete();
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin errors++; $display("FAIL abort_async: got ready=%b valid=%b result=%h want 1/0/00000000", ready_o, valid_o, result_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    send(25'h0000008, 8'h80, 1'b0, 32'h36000000);
    collect(n, ok, rh, ev);
    checks++; if (!ok || result_o !== ev) begin errors++; $display("FAIL abort_next_result: got %h want %h", result_o, ev); end
    checks++; if (n !== 22) begin errors++; $display("FAIL abort_next_latency: got %0d edges want 22", n); end
    retire();
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    mant_i = 25'h0; exp_i = 8'h0; sign_i = 1'b0;
    test_reset();
    test_carry();
    test_shift();
    test_underflow();
    test_overflow();
    test_backpressure();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_norm_stage.md
# fpu_norm_stage

Normalisation, rounding and packing stage of the pipelined FPU adder. It sits directly downstream of the mantissa add/subtract stage and consumes its 25-bit raw mantissa sum and result sign, together with the common (aligned) exponent. It produces a packed IEEE-754 single-precision word. Normalisation is iterative: at most one left shift per cycle. A valid/ready handshake on both sides stalls the pipe while a shift sequence runs.

## Interface
- Parameters: none. Widths are fixed: 25-bit raw mantissa, 8-bit exponent, 32-bit packed result.
- clk_i  input  1  clock. One clock domain; all state updates on the rising edge.
- rst_ni  input  1  reset. Asynchronous, active-low.
- valid_i  input  1  upstream holds a valid sum.
- ready_o  output  1  stage can accept; high only in IDLE.
- mant_i  input  25  raw mantissa sum. Bit 24 is the carry-out; bit 23 is the hidden-bit position.
- exp_i  input  8  common exponent after alignment.
- sign_i  input  1  result sign from the sum stage.
- valid_o  output  1  result_o holds a valid result.
- ready_i  input  1  downstream accepts result_o.
- result_o  output  32  packed word: {sign, exp[7:0], frac[22:0]}.

## Operation
- States: IDLE, NORM, DONE.
- IDLE
  - ready_o=1.
  - On valid_i&&ready_o: register mant_i, exp_i and sign_i, then go to NORM.
- NORM: exactly one of the following rules fires per cycle, in priority order.
  1. exp_r==255 → result {sign_r, 8'hFF, 23'h0} (infinity pass-through) → DONE.
  2. mant_r==0 → result {sign_r, 31'h0}. Exact cancellation arrives with sign_i=0, giving +0. → DONE.
  3. exp_r==0 → flush to signed zero {sign_r, 31'h0} → DONE.
  4. mant_r[24]==1 → right-shift by 1 with round-to-nearest-even → DONE.
     - Guard bit g = mant_r[0]; kept mantissa m = mant_r[24:1]; there is no sticky bit.
     - Round up when g && m[0].
     - If rounding carries to 2^24: m = 24'h800000 and the exponent rises by 2; otherwise it rises by 1.
     - New exponent ≥255 → infinity {sign_r, 8'hFF, 23'h0}.
  5. mant_r[23]==1 → already normal → pack {sign_r, exp_r, mant_r[22:0]} → DONE.
  6. Otherwise: if exp_r==1, flush to signed zero → DONE. Else mant_r <<= 1, exp_r -= 1, stay in NORM.
- DONE
  - valid_o=1 and result_o stable.
  - On ready_i: go to IDLE.
- No denormal outputs are produced; underflow always flushes to zero.
- Exponent arithmetic uses a 9-bit intermediate so overflow can be detected.

## Timing
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=32'h0. All internal registers are cleared.
- Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- Take the accept edge as cycle 0 and k as the number of left shifts (0–23).
  - valid_o rises after edge 2+k (rules 1–5 fire on the first NORM cycle, so k=0).
  - Flush via rule 6 also costs k+2 edges, where k counts the shifts already performed.
- ready_o is registered from state; it is low from the cycle after accept until the cycle after the DONE handshake.
- Minimum initiation interval is 3 cycles: IDLE → NORM → DONE → IDLE. There is no back-to-back accept in the handshake cycle.
- valid_o held with ready_i low: result_o and valid_o stay unchanged indefinitely.
- valid_i asserted outside IDLE is ignored; upstream must hold its data until ready_o.
- mant_i, exp_i and sign_i are sampled only on the accept edge.

## Test plan
- Reset: hold rst_ni=0 with random inputs → ready_o=1, valid_o=0, result_o=0. Release, then accept mant_i=25'h0800000, exp_i=8'h7F, sign_i=0 → result_o=32'h3F800000 (1.0) with valid_o high 2 cycles after accept.
- Carry with tie-to-even: mant_i=25'h1000001, exp_i=8'h7F → result_o=32'h40000000 (LSB even, no round-up). Then mant_i=25'h1FFFFFF, exp_i=8'h7F → result_o=32'h40800000 (round carry, exponent +2).
- Iterative shift: mant_i=25'h0000001, exp_i=8'h7F, sign_i=1 → k=23, result_o=32'hB4000000, valid_o after 25 edges, ready_o low throughout.
- Cancellation and underflow: mant_i=0, sign_i=0 → 32'h00000000 at 2 cycles. mant_i=25'h0000100, exp_i=8'h03, sign_i=1 → flush to 32'h80000000 after 2 shifts (valid_o after edge 4).
- Overflow: mant_i=25'h1000000, exp_i=8'hFE → 32'h7F800000. Input exp_i=8'hFF, sign_i=1 → 32'hFF800000.
- Backpressure and abort:
  - ready_i low for 10 cycles in DONE → result_o stable, and valid_i pulses are ignored.
  - Asserting rst_ni=0 during a 20-shift normalisation → outputs return to reset values asynchronously; the next accepted operand completes correctly.
